pattern_scan_engine: RTL

- Hardware accelerator for the bit-pattern search/count task run by software on the 9-bit processor.
- Reads N_BYTES message bytes from data memory and matches a PAT_W-bit pattern against them.
- Computes three counts: in-byte matches, bytes containing a match, and matches across the full bit stream (byte-crossing).
- Writes the three counts back to data memory, then raises done.
- Generalises the fixed 5-bit/32-byte task: parametrised pattern width, message length and counter width, plus a selectable non-overlapping count mode.

---
 rtl/pattern_scan_engine.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_scan_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pattern_scan_engine                                           |
// | Purpose  : Scans N_BYTES message bytes from data memory and counts       |
// |            occurrences of a PAT_W-bit pattern three ways:                |
// |              - cnt_inbyte : matches fully inside one byte (overlapping)  |
// |              - cnt_bytes  : bytes holding at least one in-byte match     |
// |              - cnt_cross  : matches over the whole MSB-first bit stream, |
// |                             overlapping or greedy non-overlapping        |
// |            The three counts (saturated to 8 bits) are then written to    |
// |            RES_BASE+0..2 and done is raised.                             |
// | Ports    : clk, reset (async, active high)                               |
// |            start / pat / no_overlap   - request and its operands         |
// |            mem_addr / mem_rdata       - registered address, comb. data   |
// |            mem_we / mem_wdata         - result write port                |
// |            cnt_inbyte/cnt_bytes/cnt_cross - full-width counts            |
// |            busy (SCAN, WB0..WB2), done (DONE)                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pattern_scan_engine #(
   parameter int PAT_W    = 5,
   parameter int N_BYTES  = 32,
   parameter int ADDR_W   = 8,
   parameter int MSG_BASE = 0,
   parameter int RES_BASE = 33,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PAT_W-1:0]  pat,
   input  logic              no_overlap,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic [CNT_W-1:0]  cnt_inbyte,
   output logic [CNT_W-1:0]  cnt_bytes,
   output logic [CNT_W-1:0]  cnt_cross,
   output logic              busy,
   output logic              done
);

   // History holds the last PAT_W-1 stream bits of the previous byte.
   localparam int HIST_W = PAT_W - 1;
   localparam int EXT_W  = 8 + HIST_W;
   localparam int N_WIN  = 9 - PAT_W;   // in-byte window count

   localparam logic [ADDR_W-1:0] MSG_ADDR  = ADDR_W'(MSG_BASE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_BASE + N_BYTES - 1);
   localparam logic [ADDR_W-1:0] RES_ADDR0 = ADDR_W'(RES_BASE);
   localparam logic [ADDR_W-1:0] RES_ADDR1 = ADDR_W'(RES_BASE + 1);
   localparam logic [ADDR_W-1:0] RES_ADDR2 = ADDR_W'(RES_BASE + 2);
   localparam logic [3:0]        COOL_RELOAD = 4'(PAT_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SCAN = 3'd1,
      ST_WB0  = 3'd2,
      ST_WB1  = 3'd3,
      ST_WB2  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_we_q, mem_we_d;
   logic [7:0]          mem_wdata_q, mem_wdata_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic                no_ovl_q, no_ovl_d;
   logic [HIST_W-1:0]   hist_q, hist_d;
   logic [3:0]          cool_q, cool_d;
   logic [CNT_W-1:0]    cnt_inbyte_q, cnt_inbyte_d;
   logic [CNT_W-1:0]    cnt_bytes_q, cnt_bytes_d;
   logic [CNT_W-1:0]    cnt_cross_q, cnt_cross_d;

   // Per-byte match results
   logic [EXT_W-1:0]    ext;
   logic                first_byte;
   logic [7:0]          cross_match;
   logic [3:0]          inbyte_hits;
   logic                byte_hit;
   logic [3:0]          cross_hits;
   logic [3:0]          cool_after;

   function automatic logic [7:0] sat8(input logic [CNT_W-1:0] x);
      if (x > CNT_W'(255)) begin
         return 8'hFF;
      end
      return x[7:0];
   endfunction

   // Match evaluation for the byte currently on mem_rdata.
   always_comb begin
      ext         = {hist_q, mem_rdata};
      first_byte  = (mem_addr_q == MSG_ADDR);
      inbyte_hits = 4'd0;
      cross_match = 8'd0;
      cross_hits  = 4'd0;
      cool_after  = cool_q;

      for (int k = 0; k < N_WIN; k++) begin
         if (mem_rdata[k +: PAT_W] == pat_q) begin
            inbyte_hits = inbyte_hits + 4'd1;
         end
      end
      byte_hit = (inbyte_hits != 4'd0);

      // Position j (0 = byte MSB) ends the window at ext bit 7-j; the
      // window's top bit is the earliest stream bit. In byte 0 the history
      // is not real data, so windows reaching into it are masked off.
      for (int j = 0; j < 8; j++) begin
         cross_match[j] = (ext[(7 - j) +: PAT_W] == pat_q) &&
                          (!first_byte || (j >= HIST_W));
      end

      // Greedy non-overlap: positions resolve in stream order; the cooldown
      // counts positions still suppressed and carries into the next byte.
      for (int j = 0; j < 8; j++) begin
         if (no_ovl_q) begin
            if (cool_after != 4'd0) begin
               cool_after = cool_after - 4'd1;
            end else if (cross_match[j]) begin
               cross_hits = cross_hits + 4'd1;
               cool_after = COOL_RELOAD;
            end
         end else if (cross_match[j]) begin
            cross_hits = cross_hits + 4'd1;
         end
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d      = state_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = mem_we_q;
      mem_wdata_d  = mem_wdata_q;
      pat_d        = pat_q;
      no_ovl_d     = no_ovl_q;
      hist_d       = hist_q;
      cool_d       = cool_q;
      cnt_inbyte_d = cnt_inbyte_q;
      cnt_bytes_d  = cnt_bytes_q;
      cnt_cross_d  = cnt_cross_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               pat_d        = pat;
               no_ovl_d     = no_overlap;
               cnt_inbyte_d = '0;
               cnt_bytes_d  = '0;
               cnt_cross_d  = '0;
               hist_d       = '0;
               cool_d       = 4'd0;
               mem_addr_d   = MSG_ADDR;
               state_d      = ST_SCAN;
            end
         end
         ST_SCAN: begin
            cnt_inbyte_d = cnt_inbyte_q + CNT_W'(inbyte_hits);
            cnt_bytes_d  = cnt_bytes_q + CNT_W'(byte_hit);
            cnt_cross_d  = cnt_cross_q + CNT_W'(cross_hits);
            hist_d       = mem_rdata[HIST_W-1:0];
            cool_d       = cool_after;
            if (mem_addr_q == LAST_ADDR) begin
               // The first result must reflect the final byte's update.
               mem_addr_d  = RES_ADDR0;
               mem_we_d    = 1'b1;
               mem_wdata_d = sat8(cnt_inbyte_d);
               state_d     = ST_WB0;
            end else begin
               mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
         end
         ST_WB0: begin
            mem_addr_d  = RES_ADDR1;
            mem_wdata_d = sat8(cnt_bytes_q);
            state_d     = ST_WB1;
         end
         ST_WB1: begin
            mem_addr_d  = RES_ADDR2;
            mem_wdata_d = sat8(cnt_cross_q);
            state_d     = ST_WB2;
         end
         ST_WB2: begin
            mem_we_d = 1'b0;
            state_d  = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         mem_addr_q   <= MSG_ADDR;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= 8'd0;
         pat_q        <= '0;
         no_ovl_q     <= 1'b0;
         hist_q       <= '0;
         cool_q       <= 4'd0;
         cnt_inbyte_q <= '0;
         cnt_bytes_q  <= '0;
         cnt_cross_q  <= '0;
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         pat_q        <= pat_d;
         no_ovl_q     <= no_ovl_d;
         hist_q       <= hist_d;
         cool_q       <= cool_d;
         cnt_inbyte_q <= cnt_inbyte_d;
         cnt_bytes_q  <= cnt_bytes_d;
         cnt_cross_q  <= cnt_cross_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
   assign cnt_inbyte = cnt_inbyte_q;
   assign cnt_bytes  = cnt_bytes_q;
   assign cnt_cross  = cnt_cross_q;
   assign busy       = (state_q == ST_SCAN) || (state_q == ST_WB0) ||
                       (state_q == ST_WB1)  || (state_q == ST_WB2);
   assign done       = (state_q == ST_DONE);

endmodule
`default_nettype wire
